// File: rtl/fp_norm_pkg.sv
// Shared types and helpers for the FP normalize/round pipeline.
// Default widths are single precision.
package fp_norm_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam int                  EXP_MAX   = (1 << FP_EXP_W) - 1;
    localparam logic [FP_MAN_W-1:0] QNAN_FRAC = {1'b1, {(FP_MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rnd_mode_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
        logic inv;
    } fp_flags_t;

    function automatic logic round_inc(input rnd_mode_t rm, input logic sign,
                                       input logic lsb, input logic g,
                                       input logic r, input logic s);
        logic inc;
        unique case (rm)
            RNE:     inc = g & (r | s | lsb);
            RTZ:     inc = 1'b0;
            RUP:     inc = !sign & (g | r | s);
            default: inc = sign & (g | r | s);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_normalize_round_pipe_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 32,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_val,
    output logic [CW-1:0] o_cnt
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_val[i]) o_cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normalize/round/pack for the FP adder with valid/ready on both sides.
// Define FP_SUBNORMAL_EN to produce gradual underflow instead of flush-to-zero.
module fp_normalize_round_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int GRD_W = 8,
    parameter int ACC_W = MAN_W + 1 + GRD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_cls,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic                   in_carry,
    input  logic [ACC_W-1:0]       in_mag,
    input  logic [1:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_word,
    output logic [3:0]             out_flags
);

    localparam int EW2 = EXP_W + 2;
    localparam int LZW = $clog2(ACC_W + 1);
    localparam logic [EW2-1:0]   EXP_ONES = EW2'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0] W_QNAN   = {1'b1, {(MAN_W-1){1'b0}}};

    logic [2:1] r_vld;
    logic       w_s1_en, w_s2_en;

    assign w_s2_en   = !r_vld[2] || out_ready;
    assign w_s1_en   = !r_vld[1] || w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_vld[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            if (w_s1_en) r_vld[1] <= in_valid;
            if (w_s2_en) r_vld[2] <= r_vld[1];
        end
    end

    // ---------------- stage 1: normalize ----------------
    logic [LZW-1:0]   w_lzc;
    logic [EW2-1:0]   w_e1;
    logic [ACC_W-1:0] w_m1;
    logic             w_canc;

    fp_lzc #(.W(ACC_W)) u_lzc (.i_val(in_mag), .o_cnt(w_lzc));

    // A carry-out becomes the new hidden bit; mag[0] falls into the sticky.
    always_comb begin
        w_e1 = {2'b00, in_exp} + EW2'(in_carry);
        w_m1 = {1'b1, in_mag[ACC_W-1:1]};
        if (!in_carry) begin
            w_e1 = {2'b00, in_exp} - EW2'(w_lzc);
            w_m1 = in_mag << w_lzc;
        end
        w_canc = (in_cls == CLS_NORM) && !in_carry && (in_mag == '0);
    end

    fp_class_t        r_cls;
    rnd_mode_t        r_rm;
    logic             r_sign, r_st0, r_canc;
    logic [EW2-1:0]   r_e1;
    logic [ACC_W-1:0] r_m1;

    always_ff @(posedge clk) begin
        if (in_valid && w_s1_en) begin
            r_cls  <= fp_class_t'(in_cls);
            r_rm   <= rnd_mode_t'(in_rm);
            r_sign <= in_sign;
            r_st0  <= in_carry & in_mag[0];
            r_canc <= w_canc;
            r_e1   <= w_e1;
            r_m1   <= w_m1;
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic             w_tiny, w_flush, w_st_sub;
    logic [ACC_W-1:0] w_ms;

    assign w_tiny = r_e1[EW2-1] || (r_e1 == '0);

`ifdef FP_SUBNORMAL_EN
    logic [EW2-1:0]     w_sh;
    logic [2*ACC_W-1:0] w_wide;

    // Beyond MAN_W+2 every bit already lands below the round position.
    always_comb begin
        w_sh = EW2'(1) - r_e1;
        if (!w_tiny)                       w_sh = '0;
        else if (w_sh > EW2'(MAN_W + 2))   w_sh = EW2'(MAN_W + 2);
        w_wide = {r_m1, {ACC_W{1'b0}}} >> w_sh;
    end

    assign w_ms     = w_wide[2*ACC_W-1:ACC_W];
    assign w_st_sub = |w_wide[ACC_W-1:0];
    assign w_flush  = 1'b0;
`else
    assign w_ms     = r_m1;
    assign w_st_sub = 1'b0;
    assign w_flush  = w_tiny;
`endif

    logic             w_g, w_r, w_s, w_inx, w_inc, w_ovf, w_away;
    logic [MAN_W+1:0] w_sum;
    logic [EW2-1:0]   w_eres;
    logic [EXP_W+MAN_W:0] w_word;
    fp_flags_t        w_flags;

    always_comb begin
        w_g    = w_ms[GRD_W-1];
        w_r    = w_ms[GRD_W-2];
        w_s    = (|w_ms[GRD_W-3:0]) | r_st0 | w_st_sub;
        w_inx  = w_g | w_r | w_s;
        w_inc  = round_inc(r_rm, r_sign, w_ms[GRD_W], w_g, w_r, w_s);
        w_sum  = {1'b0, w_ms[ACC_W-1:GRD_W]} + {{(MAN_W+1){1'b0}}, w_inc};
        // A subnormal that rounds into bit MAN_W becomes the smallest normal.
        w_eres = w_tiny ? EW2'(w_sum[MAN_W]) : r_e1 + EW2'(w_sum[MAN_W+1]);
        w_ovf  = !w_tiny && (w_eres >= EXP_ONES);
        w_away = (r_rm == RNE) || (r_rm == RUP && !r_sign) || (r_rm == RDN && r_sign);

        w_word      = {r_sign, w_eres[EXP_W-1:0], w_sum[MAN_W-1:0]};
        w_flags     = '0;
        w_flags.inx = w_inx;
        w_flags.unf = w_tiny & w_inx;

        unique case (r_cls)
            CLS_NAN: begin
                w_word      = {1'b0, {EXP_W{1'b1}}, W_QNAN};
                w_flags     = '0;
                w_flags.inv = 1'b1;
            end
            CLS_INF: begin
                w_word  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_flags = '0;
            end
            CLS_ZERO: begin
                w_word  = {r_sign, {(EXP_W+MAN_W){1'b0}}};
                w_flags = '0;
            end
            default: begin
                if (r_canc) begin
                    w_word  = {(r_rm == RDN), {(EXP_W+MAN_W){1'b0}}};
                    w_flags = '0;
                end else if (w_flush) begin
                    w_word      = {r_sign, {(EXP_W+MAN_W){1'b0}}};
                    w_flags     = '0;
                    w_flags.unf = 1'b1;
                    w_flags.inx = 1'b1;
                end else if (w_ovf) begin
                    w_word = w_away ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                    : {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    w_flags     = '0;
                    w_flags.ovf = 1'b1;
                    w_flags.inx = 1'b1;
                end
            end
        endcase
    end

    logic [EXP_W+MAN_W:0] r_word;
    fp_flags_t            r_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_flags <= '0;
        end else if (w_s2_en && r_vld[1]) begin
            r_word  <= w_word;
            r_flags <= w_flags;
        end
    end

    assign out_word  = r_word;
    assign out_flags = r_flags;

endmodule
